mac_out_acc: RTL and testbench
==============================

MAC_OUT_ACC -- requirements
Module: mac_out_acc

Interface
REQ-001 Parameter IN_W, 35, width of signed MAC partial sum input.
REQ-002 Parameter ACC_W, 48, width of signed accumulated result.
REQ-003 Parameter DEPTH, 4, result FIFO entries (power of 2).
REQ-004 nvdla_core_clk  in  1  sole clock; all state on rising edge.
REQ-005 nvdla_core_rstn  in  1  reset, synchronous, active-low.
REQ-006 cfg_reg_en  in  1  level enable; rising edge latches config and starts accumulation.
REQ-007 cfg_acc_len  in  8  partials per result; 0 treated as 1; sampled only on cfg_reg_en rising edge.
REQ-008 mac_out_data  in  IN_W  signed two's-complement MAC partial sum.
REQ-009 mac_out_pvld  in  1  partial valid; no backpressure toward MAC.
REQ-010 acc_out_data  out  ACC_W  signed accumulated result at FIFO head.
REQ-011 acc_out_sat  out  1  head result saturated during accumulation.
REQ-012 acc_out_pvld  out  1  FIFO non-empty.
REQ-013 acc_out_prdy  in  1  downstream ready; pop when pvld&&prdy.
REQ-014 acc_busy  out  1  state != IDLE.
REQ-015 acc_drop  out  1  sticky: result lost because FIFO full.

Function
REQ-016 States IDLE, RUN, DRAIN; IDLE->RUN on cfg_reg_en rising edge (registered previous value compared); RUN->IDLE when cfg_reg_en low and group count==0; RUN->DRAIN when cfg_reg_en low and count!=0; DRAIN->IDLE in the cycle the current group completes.
REQ-017 On IDLE->RUN: latch len (0->1), clear acc, count, acc_drop.
REQ-018 mac_out_pvld in IDLE ignored: no accumulator, counter or FIFO change.
REQ-019 RUN/DRAIN, pvld high: sum = acc + sign-extended mac_out_data; saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; saturation sets group sat flag.
REQ-020 count increments per accepted partial; when count==len-1, push {sum, sat} to FIFO, clear acc, sat, count same cycle; latency partial-in to acc_out_pvld = 1 cycle when FIFO empty.
REQ-021 Back-to-back pvld every cycle SHALL be absorbed with no gaps; new group starts cycle after push.
REQ-022 FIFO full with simultaneous pop: push accepted, occupancy unchanged.
REQ-023 FIFO full without pop: result discarded, acc_drop set, accumulator still cleared and next group proceeds.
REQ-024 Pop on empty FIFO impossible (pvld low); prdy with pvld low no effect.
REQ-025 acc_out_data/acc_out_sat SHALL be held stable while pvld high and prdy low.
REQ-026 Pointers wrap modulo DEPTH; occupancy counter of log2(DEPTH)+1 bits distinguishes full/empty.
REQ-027 cfg_reg_en toggling during DRAIN ignored until IDLE reached; len not reloaded mid-group.

Reset
REQ-028 nvdla_core_rstn low at clock edge: state IDLE, acc 0, count 0, FIFO empty, acc_out_pvld 0, acc_out_data 0, acc_out_sat 0, acc_busy 0, acc_drop 0, cfg edge register 0.
REQ-029 Reset mid-group or with FIFO occupied SHALL discard all partials and results; no output valid cycle after reset release until a new group completes.
REQ-030 cfg_reg_en already high at reset release SHALL be seen as rising edge on first post-reset cycle.

Verification
REQ-031 len=4, cfg_reg_en high, partials 1,2,3,4 consecutive, prdy=1 -> one result 10, sat=0, pvld high exactly one cycle after 4th partial.
REQ-032 len=2, partials 0x3FFFFFFFF and 0x400000000 (+max, -min 35-bit) -> result -1, sat=0; len=0 partial -5 -> result -5 (len treated 1).
REQ-033 len=1, prdy=0, 5 partials 1..5 -> FIFO holds 1,2,3,4, acc_drop=1, 5 lost; then prdy=1 -> outputs 1,2,3,4 in order, pvld low after.
REQ-034 len=3, partials 7,8 then cfg_reg_en low -> acc_busy stays 1 (DRAIN); partial 9 -> result 24, state IDLE, acc_busy 0; further pvld ignored.
REQ-035 Accumulate len=255 partials of 0x3FFFFFFFF then 2^13 groups feed acc near limit via ACC_W=36 override -> result 2^35-1, sat=1.
REQ-036 Reset asserted after 2 of 4 partials with 2 results queued -> acc_out_pvld 0, acc_busy 0; next group 1,1,1,1 -> result 4.

Source files
------------

// File: rtl/mac_out_acc.sv
// ---------------------------------------------------------------------------
// mac_out_acc
//
// Purpose:
//   Accumulates groups of signed MAC partial sums into saturated results and
//   queues them in a small result FIFO for a downstream consumer. A rising
//   edge on cfg_reg_en starts a session. Each group is cfg_acc_len partials
//   long, and a length of 0 means 1. Dropping cfg_reg_en ends the session.
//   If a group is still open at that point, the block finishes it in DRAIN
//   before it goes idle.
//
// Ports:
//   nvdla_core_clk   in   clock, all state on the rising edge
//   nvdla_core_rstn  in   synchronous active-low reset
//   cfg_reg_en       in   session enable (level); rising edge starts a session
//   cfg_acc_len      in   partials per result, latched on cfg_reg_en rise
//   mac_out_data     in   signed partial sum (IN_W bits)
//   mac_out_pvld     in   partial valid (no backpressure)
//   acc_out_data     out  signed result at FIFO head (ACC_W bits)
//   acc_out_sat      out  head result saturated during accumulation
//   acc_out_pvld     out  FIFO non-empty
//   acc_out_prdy     in   downstream ready; pop on pvld && prdy
//   acc_busy         out  state machine not idle
//   acc_drop         out  sticky: a result was lost to a full FIFO
//
// Constraints: ACC_W >= IN_W, DEPTH a power of two and >= 2.
// ---------------------------------------------------------------------------
module mac_out_acc #(
    parameter int IN_W  = 35,
    parameter int ACC_W = 48,
    parameter int DEPTH = 4
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    cfg_reg_en,
    input  logic [7:0]              cfg_acc_len,
    input  logic signed [IN_W-1:0]  mac_out_data,
    input  logic                    mac_out_pvld,
    output logic signed [ACC_W-1:0] acc_out_data,
    output logic                    acc_out_sat,
    output logic                    acc_out_pvld,
    input  logic                    acc_out_prdy,
    output logic                    acc_busy,
    output logic                    acc_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Adds a sign-extended partial to the accumulator and clamps the sum to
    // the ACC_W range. The MSB of the return value flags a clamp. The sum is
    // one bit wider than ACC_W, so it cannot wrap. The two top bits disagree
    // only when the true sum is outside the ACC_W range.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [IN_W-1:0]  b
    );
        logic signed [ACC_W:0]   wide;
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {1'b0, {(ACC_W-1){1'b1}}};
        min_v = {1'b1, {(ACC_W-1){1'b0}}};
        wide  = $signed({a[ACC_W-1], a}) +
                $signed({{(ACC_W+1-IN_W){b[IN_W-1]}}, b});
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat_add = {1'b1, (wide[ACC_W] ? min_v : max_v)};
        end else begin
            sat_add = {1'b0, wide[ACC_W-1:0]};
        end
    endfunction

    // Control and accumulator state
    logic [1:0]              state_q, state_d;
    logic                    cfg_en_q;
    logic [7:0]              len_q, len_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    grp_sat_q, grp_sat_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    drop_q, drop_d;

    // Result FIFO
    logic signed [ACC_W-1:0] data_mem_q [DEPTH];
    logic                    sat_mem_q  [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]        occ_q, occ_d;

    logic                    cfg_rise;
    logic                    accept;
    logic                    last_partial;
    logic [ACC_W:0]          add_res;
    logic signed [ACC_W-1:0] sum_val;
    logic                    sum_sat;
    logic                    fifo_full;
    logic                    pop;
    logic                    push_req;
    logic                    push;

    assign cfg_rise     = cfg_reg_en & ~cfg_en_q;
    assign accept       = mac_out_pvld & (state_q != ST_IDLE);
    assign last_partial = (cnt_q == (len_q - 8'd1));
    assign add_res      = sat_add(acc_q, mac_out_data);
    assign sum_sat      = add_res[ACC_W];
    assign sum_val      = add_res[ACC_W-1:0];

    assign fifo_full    = (occ_q == OCC_W'(DEPTH));
    assign acc_out_pvld = (occ_q != '0);
    assign pop          = acc_out_pvld & acc_out_prdy;
    assign push_req     = accept & last_partial;
    // A full FIFO still takes the push when the same cycle pops. The write
    // lands in the slot being vacated, because wr_ptr equals rd_ptr when full.
    assign push         = push_req & (~fifo_full | pop);

    // Next-state: session FSM, group accumulation, drop flag
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_d     = acc_q;
        grp_sat_d = grp_sat_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_rise) begin
                    state_d   = ST_RUN;
                    len_d     = (cfg_acc_len == 8'd0) ? 8'd1 : cfg_acc_len;
                    acc_d     = '0;
                    grp_sat_d = 1'b0;
                    cnt_d     = 8'd0;
                    drop_d    = 1'b0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (accept) begin
                    if (last_partial) begin
                        acc_d     = '0;
                        grp_sat_d = 1'b0;
                        cnt_d     = 8'd0;
                    end else begin
                        acc_d     = sum_val;
                        grp_sat_d = grp_sat_q | sum_sat;
                        cnt_d     = cnt_q + 8'd1;
                    end
                end
                if (push_req && !push) begin
                    drop_d = 1'b1;
                end
                // The exit decision uses the post-update count. A partial
                // that arrives together with the enable falling is kept.
                if (state_q == ST_RUN) begin
                    if (!cfg_reg_en) begin
                        state_d = (cnt_d == 8'd0) ? ST_IDLE : ST_DRAIN;
                    end
                end else if (push_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Register stage: control, accumulator, FIFO pointers
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q   <= ST_IDLE;
            cfg_en_q  <= 1'b0;
            len_q     <= 8'd1;
            acc_q     <= '0;
            grp_sat_q <= 1'b0;
            cnt_q     <= 8'd0;
            drop_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            cfg_en_q  <= cfg_reg_en;
            len_q     <= len_d;
            acc_q     <= acc_d;
            grp_sat_q <= grp_sat_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            occ_q     <= occ_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage needs no reset. The head is masked to zero while empty.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= sum_val;
            sat_mem_q[wr_ptr_q]  <= grp_sat_q | sum_sat;
        end
    end

    assign acc_out_data = acc_out_pvld ? data_mem_q[rd_ptr_q] : '0;
    assign acc_out_sat  = acc_out_pvld ? sat_mem_q[rd_ptr_q]  : 1'b0;
    assign acc_busy     = (state_q != ST_IDLE);
    assign acc_drop     = drop_q;

endmodule

// File: tb/tb_mac_out_acc.sv
`timescale 1ns/1ps
module tb_mac_out_acc;

    logic               clk = 1'b0;
    logic               rstn;
    logic               cfg_en;
    logic [7:0]         cfg_len;
    logic signed [34:0] din;
    logic               pvld;
    logic               prdy;

    logic signed [47:0] d48;
    logic               s48, v48, b48, dr48;
    logic signed [35:0] d36;
    logic               s36, v36, b36, dr36;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint data;
        bit     sat;
    } res_t;

    always #5 clk = ~clk;

    mac_out_acc u_dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .cfg_reg_en     (cfg_en),
        .cfg_acc_len    (cfg_len),
        .mac_out_data   (din),
        .mac_out_pvld   (pvld),
        .acc_out_data   (d48),
        .acc_out_sat    (s48),
        .acc_out_pvld   (v48),
        .acc_out_prdy   (prdy),
        .acc_busy       (b48),
        .acc_drop       (dr48)
    );

    mac_out_acc #(.IN_W(35), .ACC_W(36), .DEPTH(4)) u_dut36 (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .cfg_reg_en     (cfg_en),
        .cfg_acc_len    (cfg_len),
        .mac_out_data   (din),
        .mac_out_pvld   (pvld),
        .acc_out_data   (d36),
        .acc_out_sat    (s36),
        .acc_out_pvld   (v36),
        .acc_out_prdy   (prdy),
        .acc_busy       (b36),
        .acc_drop       (dr36)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; cfg_en = 1'b0; pvld = 1'b0; prdy = 1'b0;
        din = '0; cfg_len = 8'd0;
        step(); step();
        rstn = 1'b1;
    endtask

    task automatic start(input int len);
        cfg_en = 1'b0;
        step();
        cfg_len = len[7:0];
        cfg_en = 1'b1;
        step();
    endtask

    task automatic send(input logic signed [34:0] v);
        pvld = 1'b1;
        din  = v;
        step();
        pvld = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; cfg_en = 1'b1; pvld = 1'b1; din = 35'sd3; prdy = 1'b1; cfg_len = 8'd1;
        step(); step();
        checks++; if (v48 !== 1'b0) begin errors++; $display("FAIL reset_pvld: got %0b expected 0", v48); end
        checks++; if (d48 !== 48'sd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", d48); end
        checks++; if (s48 !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b expected 0", s48); end
        checks++; if (b48 !== 1'b0 || b36 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b/%0b expected 0", b48, b36); end
        checks++; if (dr48 !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b expected 0", dr48); end
        checks++; if (v36 !== 1'b0) begin errors++; $display("FAIL reset_pvld36: got %0b expected 0", v36); end
        pvld = 1'b0;
        rstn = 1'b1;
        step();
        checks++; if (b48 !== 1'b1) begin errors++; $display("FAIL reset_release_rise: busy got %0b expected 1", b48); end
        cfg_en = 1'b0;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        prdy = 1'b1;
        start(4);
        send(35'sd1); send(35'sd2); send(35'sd3);
        checks++; if (v48 !== 1'b0) begin errors++; $display("FAIL basic_early_pvld: got %0b expected 0", v48); end
        send(35'sd4);
        checks++; if (v48 !== 1'b1) begin errors++; $display("FAIL basic_pvld: got %0b expected 1", v48); end
        checks++; if (d48 !== 48'sd10) begin errors++; $display("FAIL basic_data: got %0d expected 10", d48); end
        checks++; if (s48 !== 1'b0) begin errors++; $display("FAIL basic_sat: got %0b expected 0", s48); end
        step();
        checks++; if (v48 !== 1'b0) begin errors++; $display("FAIL basic_pop: pvld got %0b expected 0", v48); end
    endtask

    task automatic test_extremes();
        do_reset();
        prdy = 1'b1;
        start(2);
        send(35'sh3FFFFFFFF);
        send(35'sh400000000);
        checks++; if (v48 !== 1'b1 || d48 !== -48'sd1) begin errors++; $display("FAIL extreme_sum: pvld %0b data %0d expected 1/-1", v48, d48); end
        checks++; if (s48 !== 1'b0) begin errors++; $display("FAIL extreme_sat: got %0b expected 0", s48); end
        start(0);
        send(-35'sd5);
        checks++; if (v48 !== 1'b1 || d48 !== -48'sd5) begin errors++; $display("FAIL len0_data: pvld %0b data %0d expected 1/-5", v48, d48); end
    endtask

    task automatic test_drop();
        do_reset();
        prdy = 1'b0;
        start(1);
        for (int i = 1; i <= 5; i++) send(35'(i));
        checks++; if (v48 !== 1'b1 || d48 !== 48'sd1) begin errors++; $display("FAIL drop_head: pvld %0b data %0d expected 1/1", v48, d48); end
        checks++; if (dr48 !== 1'b1) begin errors++; $display("FAIL drop_flag: got %0b expected 1", dr48); end
        step(); step();
        checks++; if (d48 !== 48'sd1 || s48 !== 1'b0) begin errors++; $display("FAIL drop_hold: data %0d expected 1", d48); end
        prdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (v48 !== 1'b1 || d48 !== 48'(i)) begin errors++; $display("FAIL drop_order: pvld %0b data %0d expected 1/%0d", v48, d48, i); end
            step();
        end
        checks++; if (v48 !== 1'b0) begin errors++; $display("FAIL drop_empty: pvld got %0b expected 0", v48); end
        checks++; if (dr48 !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %0b expected 1", dr48); end
    endtask

    task automatic test_drain();
        do_reset();
        prdy = 1'b1;
        start(3);
        send(35'sd7); send(35'sd8);
        cfg_en = 1'b0;
        step();
        checks++; if (b48 !== 1'b1) begin errors++; $display("FAIL drain_busy: got %0b expected 1", b48); end
        cfg_len = 8'd1; cfg_en = 1'b1;
        step();
        cfg_en = 1'b0;
        step();
        checks++; if (b48 !== 1'b1 || v48 !== 1'b0) begin errors++; $display("FAIL drain_toggle: busy %0b pvld %0b expected 1/0", b48, v48); end
        send(35'sd9);
        checks++; if (v48 !== 1'b1 || d48 !== 48'sd24) begin errors++; $display("FAIL drain_result: pvld %0b data %0d expected 1/24", v48, d48); end
        checks++; if (b48 !== 1'b0) begin errors++; $display("FAIL drain_idle: busy got %0b expected 0", b48); end
        pvld = 1'b1; din = 35'sd100;
        for (int i = 0; i < 4; i++) step();
        pvld = 1'b0;
        checks++; if (v48 !== 1'b0 || b48 !== 1'b0) begin errors++; $display("FAIL idle_ignore: pvld %0b busy %0b expected 0/0", v48, b48); end
    endtask

    task automatic test_sat();
        longint e;
        do_reset();
        prdy = 1'b1;
        start(255);
        for (int i = 0; i < 255; i++) send(35'sh3FFFFFFFF);
        e = 64'sd255 * 64'sh3FFFFFFFF;
        checks++; if (v36 !== 1'b1 || d36 !== 36'sh7FFFFFFFF) begin errors++; $display("FAIL sat_pos36: pvld %0b data %0h expected 1/7ffffffff", v36, d36); end
        checks++; if (s36 !== 1'b1) begin errors++; $display("FAIL sat_flag36: got %0b expected 1", s36); end
        checks++; if (d48 !== e[47:0] || s48 !== 1'b0) begin errors++; $display("FAIL nosat48: data %0d sat %0b expected %0d/0", d48, s48, e); end
        start(3);
        for (int i = 0; i < 3; i++) send(35'sh400000000);
        e = -64'sd3 * (64'sd1 <<< 34);
        checks++; if (d36 !== 36'sh800000000 || s36 !== 1'b1) begin errors++; $display("FAIL sat_neg36: data %0h sat %0b expected 800000000/1", d36, s36); end
        checks++; if (d48 !== e[47:0] || s48 !== 1'b0) begin errors++; $display("FAIL neg48: data %0d sat %0b expected %0d/0", d48, s48, e); end
        for (int i = 0; i < 3; i++) send(35'sd1);
        checks++; if (d36 !== 36'sd3 || s36 !== 1'b0) begin errors++; $display("FAIL sat_clear36: data %0d sat %0b expected 3/0", d36, s36); end
        checks++; if (dr36 !== 1'b0) begin errors++; $display("FAIL sat_drop36: got %0b expected 0", dr36); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        prdy = 1'b0;
        start(1);
        send(35'sd1); send(35'sd2);
        checks++; if (v48 !== 1'b1) begin errors++; $display("FAIL midrst_queued: pvld got %0b expected 1", v48); end
        start(4);
        send(35'sd1); send(35'sd1);
        rstn = 1'b0;
        step();
        checks++; if (v48 !== 1'b0 || b48 !== 1'b0 || d48 !== 48'sd0) begin errors++; $display("FAIL midrst_clear: pvld %0b busy %0b data %0d expected 0/0/0", v48, b48, d48); end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (v48 !== 1'b0) begin errors++; $display("FAIL midrst_quiet: pvld got %0b expected 0", v48); end
        end
        prdy = 1'b1;
        start(4);
        for (int i = 0; i < 4; i++) send(35'sd1);
        checks++; if (v48 !== 1'b1 || d48 !== 48'sd4) begin errors++; $display("FAIL midrst_next: pvld %0b data %0d expected 1/4", v48, d48); end
    endtask

    task automatic test_random();
        res_t   exp_q[$];
        res_t   r;
        longint amax, amin, acc_m, sum, v, hd;
        int     len_m, cnt_m, len_cfg, sel;
        bit     sat_m, drop_m, pop_m, full_m;
        logic [34:0] raw;
        amax = (64'sd1 <<< 47) - 1;
        amin = -(64'sd1 <<< 47);
        for (int run = 0; run < 3; run++) begin
            do_reset();
            exp_q.delete();
            len_cfg = $urandom_range(0, 5);
            len_m = (len_cfg == 0) ? 1 : len_cfg;
            acc_m = 0; cnt_m = 0; sat_m = 0; drop_m = 0;
            start(len_cfg);
            for (int c = 0; c < 250; c++) begin
                sel = $urandom_range(0, 7);
                raw = 35'({$urandom, $urandom});
                if (sel == 0) raw = 35'h3FFFFFFFF;
                if (sel == 1) raw = 35'h400000000;
                din  = raw;
                pvld = ($urandom_range(0, 3) != 0);
                prdy = ($urandom_range(0, 2) != 0);
                // Reference: FIFO as a queue, a group as a clamped running sum
                full_m = (exp_q.size() == 4);
                pop_m  = (exp_q.size() != 0) && prdy;
                if (pop_m) void'(exp_q.pop_front());
                if (pvld) begin
                    v = din;
                    sum = acc_m + v;
                    if (sum > amax) begin sum = amax; sat_m = 1; end
                    if (sum < amin) begin sum = amin; sat_m = 1; end
                    cnt_m++;
                    if (cnt_m == len_m) begin
                        r.data = sum; r.sat = sat_m;
                        if (!full_m || pop_m) exp_q.push_back(r);
                        else drop_m = 1;
                        acc_m = 0; sat_m = 0; cnt_m = 0;
                    end else begin
                        acc_m = sum;
                    end
                end
                step();
                checks++; if (v48 !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_pvld: cycle %0d got %0b expected %0b", c, v48, exp_q.size() != 0); end
                if (exp_q.size() != 0) begin
                    hd = exp_q[0].data;
                    checks++; if (d48 !== hd[47:0] || s48 !== exp_q[0].sat) begin errors++; $display("FAIL rand_data: cycle %0d got %0d/%0b expected %0d/%0b", c, d48, s48, hd, exp_q[0].sat); end
                end
                checks++; if (dr48 !== drop_m) begin errors++; $display("FAIL rand_drop: cycle %0d got %0b expected %0b", c, dr48, drop_m); end
            end
            pvld = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_drop();
        test_drain();
        test_sat();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
